// File: rtl/lc3_mem_pkg.sv
// Shared LC-3 memory-side types: mem_state encodings, data-memory FSM states, word type.
package lc3_mem_pkg;

    typedef logic [15:0] lc3_word_t;

    localparam logic [1:0] MS_READ     = 2'b00;
    localparam logic [1:0] MS_READ_IND = 2'b01;
    localparam logic [1:0] MS_WRITE    = 2'b10;
    localparam logic [1:0] MS_IDLE     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/lc3_dmem_array.sv
// 2^ADDR_BITS x 16 storage with one synchronous write port and one registered read port.
module lc3_dmem_array
    import lc3_mem_pkg::*;
#(
    parameter int        ADDR_BITS = 8,
    parameter lc3_word_t INIT_VAL  = 16'h0000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  lc3_word_t            wdata,
    output lc3_word_t            rdata
);

    // Power-up contents only; reset leaves the storage untouched.
    lc3_word_t mem [2**ADDR_BITS] = '{default: INIT_VAL};

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/lc3_data_mem.sv
// LC-3 data memory with configurable access latency and a one-cycle completion pulse.
module lc3_data_mem
    import lc3_mem_pkg::*;
#(
    parameter int        ADDR_BITS = 8,
    parameter int        LATENCY   = 2,
    parameter lc3_word_t INIT_VAL  = 16'h0000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mem_state,
    input  lc3_word_t  Data_addr,
    input  lc3_word_t  Data_din,
    input  logic       Data_rd,
    output lc3_word_t  Data_dout,
    output logic       complete_data
);

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    dmem_state_t          state;
    logic [2:0]           cnt;
    logic [ADDR_BITS-1:0] cap_addr;
    lc3_word_t            cap_din;
    logic                 cap_rd;

    logic                 req;
    logic                 access;
    logic [ADDR_BITS-1:0] acc_addr;
    lc3_word_t            acc_din;
    logic                 acc_rd;

    assign req = (state == IDLE) && (mem_state != MS_IDLE);

    // The acceptance edge counts toward LATENCY: the access happens on the edge
    // where the counter reaches zero, which is the acceptance edge itself when LATENCY=1.
    assign access = !reset && ((req && CNT_INIT == 3'd0) || (state == BUSY && cnt == 3'd1));

    assign acc_addr = (state == IDLE) ? Data_addr[ADDR_BITS-1:0] : cap_addr;
    assign acc_din  = (state == IDLE) ? Data_din : cap_din;
    assign acc_rd   = (state == IDLE) ? Data_rd  : cap_rd;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            complete_data <= 1'b0;
            cap_addr      <= '0;
            cap_din       <= '0;
            cap_rd        <= 1'b0;
        end else begin
            complete_data <= access;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_addr <= Data_addr[ADDR_BITS-1:0];
                        cap_din  <= Data_din;
                        cap_rd   <= Data_rd;
                        cnt      <= CNT_INIT;
                        state    <= access ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 3'd1;
                    if (access) begin
                        state <= DONE;
                    end
                end
                // mem_state is still stale here, so never accept on this edge.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (ADDR_BITS < 16) begin : g_alias
            logic unused_upper;
            assign unused_upper = ^Data_addr[15:ADDR_BITS];
        end
    endgenerate

    lc3_dmem_array #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_VAL  (INIT_VAL)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (access && !acc_rd),
        .re    (access && acc_rd),
        .addr  (acc_addr),
        .wdata (acc_din),
        .rdata (Data_dout)
    );

endmodule

// File: tb/tb_lc3_data_mem.sv
// Bench for lc3_data_mem: LATENCY=2 and LATENCY=3 instances against a word-array model.
module tb_lc3_data_mem;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic [1:0]  ms    [2];
    logic [15:0] addr  [2];
    logic [15:0] din   [2];
    logic        rd    [2];
    logic [15:0] dout  [2];
    logic        cd    [2];
    logic [15:0] dout0, dout1;
    logic        cd0, cd1;

    int checks   = 0;
    int failures = 0;

    int          lat_of  [2] = '{2, 3};
    logic [15:0] mdl_mem [2][256];
    logic [15:0] mdl_dout[2];

    typedef struct {
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] d;
        logic        r;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    lc3_data_mem #(.ADDR_BITS(8), .LATENCY(2), .INIT_VAL(16'h0000)) u_dut0 (
        .clock(clk), .reset(rst[0]), .mem_state(ms[0]), .Data_addr(addr[0]),
        .Data_din(din[0]), .Data_rd(rd[0]), .Data_dout(dout0), .complete_data(cd0));

    lc3_data_mem #(.ADDR_BITS(8), .LATENCY(3), .INIT_VAL(16'h5A5A)) u_dut1 (
        .clock(clk), .reset(rst[1]), .mem_state(ms[1]), .Data_addr(addr[1]),
        .Data_din(din[1]), .Data_rd(rd[1]), .Data_dout(dout1), .complete_data(cd1));

    always_comb begin
        dout[0] = dout0;
        dout[1] = dout1;
        cd[0]   = cd0;
        cd[1]   = cd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Counts negedges until complete_data is seen; 99 means it never came.
    task automatic wait_pulse(input int idx, output int n);
        n = 99;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (cd[idx]) begin
                n = k;
                break;
            end
        end
    endtask

    // Starts and ends at a negedge with the FSM in IDLE.
    task automatic do_access(input int idx, input logic [1:0] m, input logic [15:0] a,
                             input logic [15:0] d, input logic r, output logic [15:0] got);
        int n;
        ms[idx] = m; addr[idx] = a; din[idx] = d; rd[idx] = r;
        wait_pulse(idx, n);
        got = dout[idx];
        ms[idx] = 2'b11;
        check("latency", n, lat_of[idx]);
        if (r) mdl_dout[idx] = mdl_mem[idx][a[7:0]];
        else   mdl_mem[idx][a[7:0]] = d;
        check("dout", got, mdl_dout[idx]);
        @(negedge clk);
        check("pulse_single", cd[idx], 1'b0);
    endtask

    initial begin
        logic [15:0] got;
        int n, pulses;

        for (int i = 0; i < 256; i++) begin
            mdl_mem[0][i] = 16'h0000;
            mdl_mem[1][i] = 16'h5A5A;
        end
        tbl[0] = '{2'b10, 16'h0012, 16'hBEEF, 1'b0, 16'h0000};
        tbl[1] = '{2'b00, 16'h0012, 16'h0000, 1'b1, 16'hBEEF};
        tbl[2] = '{2'b10, 16'h0105, 16'h1234, 1'b0, 16'hBEEF};
        tbl[3] = '{2'b00, 16'h0005, 16'h0000, 1'b1, 16'h1234};
        tbl[4] = '{2'b01, 16'h0099, 16'hFFFF, 1'b1, 16'h0000};
        tbl[5] = '{2'b01, 16'h0077, 16'h5555, 1'b0, 16'h0000};
        tbl[6] = '{2'b10, 16'hFF77, 16'h0000, 1'b1, 16'h5555};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; ms[i] = 2'b11; addr[i] = '0; din[i] = '0; rd[i] = 1'b0;
            mdl_dout[i] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("reset_cd", cd[i], 1'b0);
                check("reset_dout", dout[i], 16'h0000);
            end
        end

        // Directed table on the LATENCY=2 instance
        for (int i = 0; i < 7; i++) begin
            do_access(0, tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].r, got);
            check($sformatf("tbl%0d", i), got, tbl[i].exp);
        end

        // Reset mid-write: the write to 0x30 must be dropped
        do_access(0, 2'b10, 16'h0030, 16'h1111, 1'b0, got);
        ms[0] = 2'b10; addr[0] = 16'h0030; din[0] = 16'hAAAA; rd[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1; ms[0] = 2'b11;
        @(negedge clk);
        check("rst_mid_cd", cd[0], 1'b0);
        @(negedge clk);
        rst[0] = 1'b0;
        mdl_dout[0] = 16'h0000;
        check("rst_mid_dout", dout[0], 16'h0000);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (cd[0]) pulses++;
        end
        check("rst_mid_nopulse", pulses, 0);
        do_access(0, 2'b00, 16'h0030, 16'h0000, 1'b1, got);
        check("rst_mid_prior", got, 16'h1111);

        // Indirect load on the LATENCY=3 instance
        do_access(1, 2'b00, 16'h0033, 16'h0000, 1'b1, got);
        check("init_val", got, 16'h5A5A);
        do_access(1, 2'b10, 16'h0020, 16'h0040, 1'b0, got);
        do_access(1, 2'b10, 16'h0040, 16'h7777, 1'b0, got);
        ms[1] = 2'b01; addr[1] = 16'h0020; rd[1] = 1'b1;
        wait_pulse(1, n);
        check("ind_lat1", n, 3);
        check("ind_ptr", dout[1], 16'h0040);
        ms[1] = 2'b00; addr[1] = 16'h0040;
        wait_pulse(1, n);
        ms[1] = 2'b11;
        check("ind_lat2", n, 4);
        check("ind_data", dout[1], 16'h7777);
        mdl_dout[1] = 16'h7777;
        @(negedge clk);
        check("ind_single", cd[1], 1'b0);

        // Inputs changed during BUSY are ignored
        ms[1] = 2'b00; addr[1] = 16'h0020; rd[1] = 1'b1; din[1] = 16'h0000;
        @(negedge clk);
        ms[1] = 2'b11; addr[1] = 16'h0040; rd[1] = 1'b0; din[1] = 16'hDEAD;
        wait_pulse(1, n);
        check("busy_chg_lat", n, 2);
        check("busy_chg_dout", dout[1], 16'h0040);
        mdl_dout[1] = 16'h0040;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (cd[1]) pulses++;
        end
        check("busy_chg_once", pulses, 0);
        do_access(1, 2'b00, 16'h0040, 16'h0000, 1'b1, got);
        check("busy_chg_nowrite", got, 16'h7777);

        // Randomized traffic against the model, aliased over 16 low addresses
        for (int it = 0; it < 60; it++) begin
            int idx;
            logic [15:0] a;
            idx = it % 2;
            a = {8'($urandom), 8'h80 + 8'($urandom_range(0, 15))};
            do_access(idx, 2'($urandom_range(0, 2)), a, 16'($urandom), 1'($urandom), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
